// File: rtl/elevator_scan_scheduler.sv
// rtl/elevator_scan_scheduler.sv - SCAN-policy elevator call scheduler
module elevator_scan_scheduler #(
    parameter int NUM_FLOORS    = 3,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  dir_up,
    output logic                  is_moving,
    output logic                  door_open,
    output logic                  arrived
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] ONE = FLOOR_W'(1);
    localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t                 state, state_n;
    logic [TW-1:0]          tcnt, tcnt_n;
    logic [DW-1:0]          dcnt, dcnt_n;
    logic [FLOOR_W-1:0]     floor_n, step_floor, door_floor;
    logic                   dir_n, enter_door;
    logic                   ahead_up, ahead_dn, hit_cur;
    logic                   step_ahead_up, step_ahead_dn, hit_step, call_here;
    logic [NUM_FLOORS-1:0]  clear_mask;

    // Floor the car reaches if it completes one step in the current direction, clamped to the shaft
    always_comb begin
        step_floor = cur_floor;
        if (dir_up && (cur_floor < TOP))
            step_floor = cur_floor + ONE;
        else if (!dir_up && (cur_floor != '0))
            step_floor = cur_floor - ONE;
    end

    // Pending-call lookups; loops only visit real floors so unused floor codes read as empty
    always_comb begin
        ahead_up      = 1'b0;
        ahead_dn      = 1'b0;
        hit_cur       = 1'b0;
        step_ahead_up = 1'b0;
        step_ahead_dn = 1'b0;
        hit_step      = 1'b0;
        call_here     = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (i >  int'(cur_floor))  ahead_up      = 1'b1;
                if (i <  int'(cur_floor))  ahead_dn      = 1'b1;
                if (i == int'(cur_floor))  hit_cur       = 1'b1;
                if (i >  int'(step_floor)) step_ahead_up = 1'b1;
                if (i <  int'(step_floor)) step_ahead_dn = 1'b1;
                if (i == int'(step_floor)) hit_step      = 1'b1;
            end
            if (call_req[i] && (i == int'(cur_floor))) call_here = 1'b1;
        end
    end

    // Nearest pending floor strictly ahead in the travel direction, else the current floor
    always_comb begin
        target_floor = cur_floor;
        if (dir_up) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--)
                if (pending[i] && (i > int'(cur_floor))) target_floor = FLOOR_W'(i);
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++)
                if (pending[i] && (i < int'(cur_floor))) target_floor = FLOOR_W'(i);
        end
    end

    // SCAN next-state: serve here, continue ahead, or reverse; door call at the open floor restarts the timer
    always_comb begin
        state_n    = state;
        dir_n      = dir_up;
        floor_n    = cur_floor;
        tcnt_n     = tcnt;
        dcnt_n     = dcnt;
        enter_door = 1'b0;
        door_floor = cur_floor;
        case (state)
            IDLE: begin
                if (hit_cur) begin
                    state_n    = DOOR;
                    enter_door = 1'b1;
                    dcnt_n     = '0;
                end else if (dir_up ? ahead_up : ahead_dn) begin
                    state_n = MOVE;
                    tcnt_n  = '0;
                end else if (dir_up ? ahead_dn : ahead_up) begin
                    dir_n   = ~dir_up;
                    state_n = MOVE;
                    tcnt_n  = '0;
                end
            end
            MOVE: begin
                if (tcnt == T_LAST) begin
                    tcnt_n  = '0;
                    floor_n = step_floor;
                    if (hit_step) begin
                        state_n    = DOOR;
                        enter_door = 1'b1;
                        door_floor = step_floor;
                        dcnt_n     = '0;
                    end else if (!(dir_up ? step_ahead_up : step_ahead_dn)) begin
                        state_n = IDLE;
                    end
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            DOOR: begin
                if (call_here) begin
                    dcnt_n = '0;
                end else if (dcnt == D_LAST) begin
                    dcnt_n  = '0;
                    state_n = IDLE;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Clear the served floor on door entry and keep it clear while the door is open
    always_comb begin
        clear_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (enter_door && (i == int'(door_floor)))
                clear_mask[i] = 1'b1;
            else if ((state == DOOR) && (i == int'(cur_floor)))
                clear_mask[i] = 1'b1;
        end
    end

    // State, counters, latched calls and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            dcnt      <= '0;
            cur_floor <= '0;
            dir_up    <= 1'b1;
            pending   <= '0;
            is_moving <= 1'b0;
            door_open <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            dcnt      <= dcnt_n;
            cur_floor <= floor_n;
            dir_up    <= dir_n;
            pending   <= (pending | call_req) & ~clear_mask;
            is_moving <= (state_n == MOVE);
            door_open <= (state_n == DOOR);
            arrived   <= enter_door;
        end
    end

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// tb/tb_elevator_scan_scheduler.sv - self-checking bench for elevator_scan_scheduler
module tb_elevator_scan_scheduler;

    localparam int NF = 4;
    localparam int TC = 4;
    localparam int DC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] call_req;
    logic [NF-1:0] pending;
    logic [1:0]    cur_floor, target_floor;
    logic          dir_up, is_moving, door_open, arrived;

    int total = 0;
    int bad   = 0;

    // model: mode 0 idle, 1 travelling, 2 door open; timers count down remaining cycles
    bit [NF-1:0] m_pend;
    int          m_floor, m_mode, m_travel, m_door;
    bit          m_dir, m_arr;

    elevator_scan_scheduler #(
        .NUM_FLOORS(NF), .FLOOR_W(2), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .pending(pending),
        .cur_floor(cur_floor), .target_floor(target_floor), .dir_up(dir_up),
        .is_moving(is_moving), .door_open(door_open), .arrived(arrived)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_any(input bit up, input int from);
        for (int i = 0; i < NF; i++)
            if (m_pend[i] && (up ? (i > from) : (i < from))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_target();
        if (m_dir) begin
            for (int i = m_floor + 1; i < NF; i++) if (m_pend[i]) return i;
        end else begin
            for (int i = m_floor - 1; i >= 0; i--) if (m_pend[i]) return i;
        end
        return m_floor;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_floor = 0; m_mode = 0; m_travel = 0; m_door = 0;
        m_dir = 1'b1; m_arr = 1'b0;
    endtask

    task automatic model_step(input bit [NF-1:0] req);
        int old_mode;
        bit open;
        old_mode = m_mode;
        open = 1'b0;
        case (m_mode)
            0: begin
                if (m_pend[m_floor]) open = 1'b1;
                else if (m_any(m_dir, m_floor)) begin m_mode = 1; m_travel = TC; end
                else if (m_any(!m_dir, m_floor)) begin m_dir = !m_dir; m_mode = 1; m_travel = TC; end
            end
            1: begin
                m_travel--;
                if (m_travel == 0) begin
                    m_floor += m_dir ? 1 : -1;
                    if (m_pend[m_floor]) open = 1'b1;
                    else if (m_any(m_dir, m_floor)) m_travel = TC;
                    else m_mode = 0;
                end
            end
            default: begin
                if (req[m_floor]) m_door = DC;
                else begin
                    m_door--;
                    if (m_door == 0) m_mode = 0;
                end
            end
        endcase
        if (open) begin m_mode = 2; m_door = DC; end
        m_arr  = open;
        m_pend = m_pend | req;
        if (open || old_mode == 2) m_pend[m_floor] = 1'b0;
    endtask

    task automatic compare_all();
        check("pending",   int'(pending),      int'(m_pend));
        check("cur_floor", int'(cur_floor),    m_floor);
        check("target",    int'(target_floor), m_target());
        check("dir_up",    int'(dir_up),       int'(m_dir));
        check("is_moving", int'(is_moving),    int'(m_mode == 1));
        check("door_open", int'(door_open),    int'(m_mode == 2));
        check("arrived",   int'(arrived),      int'(m_arr));
    endtask

    // one clock: drive request, advance model at the edge, compare at the falling edge
    task automatic cycle(input logic [NF-1:0] req);
        call_req = req;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(req);
        @(negedge clk);
        compare_all();
    endtask

    int n, dc, arr_cnt, mv, first_move;
    int arr_floor[4];
    int arr_dir[4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        call_req = '0;
        model_reset();
        repeat (3) cycle(4'b0000);
        rst_n = 1'b1;

        // reset idle
        mv = 0;
        repeat (20) begin cycle(4'b0000); mv |= int'(is_moving); end
        check("idle_floor_lit", int'(cur_floor), 0);
        check("idle_dir_lit", int'(dir_up), 1);
        check("idle_move_lit", mv, 0);

        // same-floor call
        cycle(4'b0001);
        check("same_pend_lit", int'(pending), 1);
        dc = 0; arr_cnt = 0; mv = 0;
        repeat (12) begin
            cycle(4'b0000);
            dc += int'(door_open); arr_cnt += int'(arrived); mv |= int'(is_moving);
        end
        check("same_door_lit", dc, 8);
        check("same_arr_lit", arr_cnt, 1);
        check("same_move_lit", mv, 0);

        // single trip up
        cycle(4'b1000);
        n = 0; first_move = -1;
        while (!arrived && n < 40) begin
            cycle(4'b0000);
            n++;
            if (is_moving && first_move < 0) first_move = n;
        end
        check("trip_move_start_lit", first_move, 1);
        check("trip_cycles_lit", n, 13);
        check("trip_floor_lit", int'(cur_floor), 3);
        check("trip_dir_lit", int'(dir_up), 1);
        check("trip_pend_lit", int'(pending), 0);
        repeat (10) cycle(4'b0000);

        // SCAN order
        rst_n = 1'b0;
        cycle(4'b0000);
        rst_n = 1'b1;
        cycle(4'b1000);
        n = 0;
        while (cur_floor != 2'd1 && n < 20) begin cycle(4'b0000); n++; end
        check("scan_reach1", int'(cur_floor), 1);
        cycle(4'b0101);
        arr_cnt = 0;
        repeat (80) begin
            cycle(4'b0000);
            if (arrived) begin
                if (arr_cnt < 4) begin
                    arr_floor[arr_cnt] = int'(cur_floor);
                    arr_dir[arr_cnt] = int'(dir_up);
                end
                arr_cnt++;
            end
        end
        check("scan_arr_cnt_lit", arr_cnt, 3);
        if (arr_cnt >= 3) begin
            check("scan_first_lit", arr_floor[0], 2);
            check("scan_second_lit", arr_floor[1], 3);
            check("scan_third_lit", arr_floor[2], 0);
            check("scan_rev_dir_lit", arr_dir[2], 0);
        end

        // door extension at floor 2
        cycle(4'b0100);
        n = 0;
        while (!arrived && n < 40) begin cycle(4'b0000); n++; end
        check("ext_floor_lit", int'(cur_floor), 2);
        dc = int'(door_open);
        repeat (6) begin cycle(4'b0000); dc += int'(door_open); end
        cycle(4'b0100);
        dc += int'(door_open);
        check("ext_pend2_lit", int'(pending[2]), 0);
        n = 0;
        while (door_open && n < 40) begin
            cycle(4'b0000);
            dc += int'(door_open);
            n++;
        end
        check("ext_door_len_lit", dc, 15);

        // reset mid-travel
        cycle(4'b0001);
        cycle(4'b1000);
        cycle(4'b0000);
        check("mid_moving_lit", int'(is_moving), 1);
        check("mid_pend_lit", int'(pending), 9);
        check("mid_floor_lit", int'(cur_floor), 2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_pend_lit", int'(pending), 0);
        check("rst_floor_lit", int'(cur_floor), 0);
        check("rst_dir_lit", int'(dir_up), 1);
        check("rst_move_lit", int'(is_moving), 0);
        check("rst_door_lit", int'(door_open), 0);
        check("rst_arr_lit", int'(arrived), 0);
        cycle(4'b0000);
        cycle(4'b0000);
        rst_n = 1'b1;
        mv = 0;
        repeat (20) begin cycle(4'b0000); mv |= int'(is_moving); end
        check("post_rst_move_lit", mv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
